// File: rtl/rpsc_pkg.sv
// -----------------------------------------------------------------------------
// rpsc_pkg
// Shared types and constants for the RPSC cathode-supply interlock sequencer.
//   state_t          : sequencer state codes, also driven out on the state port
//   CAUSE_NONE       : no latched fault
//   CAUSE_PERMIT     : supply-on permit lost while the supply was active
//   CAUSE_TRIP_BASE  : trip_in[k] is reported as CAUSE_TRIP_BASE + k
// -----------------------------------------------------------------------------
package rpsc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RAMP   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_TRIP   = 3'd4
    } state_t;

    localparam int CAUSE_NONE      = 0;
    localparam int CAUSE_PERMIT    = 1;
    localparam int CAUSE_TRIP_BASE = 2;

endpackage

// File: rtl/rpsc_debounce.sv
// -----------------------------------------------------------------------------
// rpsc_debounce
// One-bit debounce filter. The filtered output follows the raw input only
// after the raw value has differed from it for DEB_CYC consecutive clocks;
// any shorter excursion is discarded.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset (filtered value returns to 0)
//   raw   : unfiltered input
//   db    : filtered output
// -----------------------------------------------------------------------------
module rpsc_debounce
    import rpsc_pkg::*;
#(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int                CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DEB_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement or process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (raw == db) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            // DEB_CYC-th consecutive disagreeing sample: accept the new value.
            db  <= raw;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rpsc_interlock_seq.sv
// -----------------------------------------------------------------------------
// rpsc_interlock_seq
// Cathode-supply interlock and sequencer. Debounces the status-fault inputs,
// derives the supply-on permit, and walks the supply through ramp and settle
// delays into RUN. In SETTLE/RUN a permit loss or trip request forces TRIP,
// latching the trip bits and the winning cause until operator acknowledge.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   stat_fault    : raw status faults (1 = fault), debounced per bit
//   g1_not_ok     : grid-1 supply not OK (1 = inhibit)
//   fan_ok        : fan running (1 = OK)
//   ps_act        : operator supply-on request
//   trip_in       : run-time trip requests, sampled raw
//   ack           : fault acknowledge (effective only with ps_act low)
//   not_alarm     : no debounced status fault
//   on_perm       : registered supply-on permit
//   ps_on         : supply contactor drive (RAMP/SETTLE/RUN)
//   delay_done    : ramp complete (SETTLE/RUN)
//   ca_ok         : supply in RUN
//   trip_latched  : trip bits captured on the trip clock
//   first_cause   : 0 none, 1 permit loss, 2+k trip_in[k]
//   state         : current state code
// -----------------------------------------------------------------------------
module rpsc_interlock_seq
    import rpsc_pkg::*;
#(
    parameter int N_STAT     = 7,
    parameter int N_TRIP     = 2,
    parameter int DEB_CYC    = 4,
    parameter int RAMP_CYC   = 256,
    parameter int SETTLE_CYC = 3840,
    parameter int CNT_W      = $clog2(((RAMP_CYC > SETTLE_CYC) ? RAMP_CYC : SETTLE_CYC) + 1),
    parameter int CW         = $clog2(N_TRIP + 2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_STAT-1:0] stat_fault,
    input  logic              g1_not_ok,
    input  logic              fan_ok,
    input  logic              ps_act,
    input  logic [N_TRIP-1:0] trip_in,
    input  logic              ack,
    output logic              not_alarm,
    output logic              on_perm,
    output logic              ps_on,
    output logic              delay_done,
    output logic              ca_ok,
    output logic [N_TRIP-1:0] trip_latched,
    output logic [CW-1:0]     first_cause,
    output logic [2:0]        state
);

    localparam logic [CNT_W-1:0] RAMP_LAST   = CNT_W'(RAMP_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    logic [N_STAT-1:0] db;
    logic              permit;
    logic [CW-1:0]     trip_code;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_TRIP-1:0] latched_d;
    logic [CW-1:0]     cause_d;

    for (genvar i = 0; i < N_STAT; i++) begin : g_deb
        rpsc_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (stat_fault[i]),
            .db    (db[i])
        );
    end

    // Permit is taken from the filtered faults; the sequencer acts on it
    // directly, on_perm is only its registered copy for the status outputs.
    assign not_alarm = ~(|db);
    assign permit    = not_alarm & ~g1_not_ok & fan_ok;

    // Lowest-index active trip wins, so scan downward and let it overwrite.
    always_comb begin
        trip_code = CW'(CAUSE_NONE);
        for (int k = N_TRIP - 1; k >= 0; k--) begin
            if (trip_in[k]) trip_code = CW'(CAUSE_TRIP_BASE + k);
        end
    end

    // NOTE: every variable is given a hold/default value before the case so
    // no path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latched_d = trip_latched;
        cause_d   = first_cause;
        case (state_q)
            ST_IDLE: begin
                if (permit && ps_act) begin
                    state_d = ST_RAMP;
                    cnt_d   = '0;
                end
            end
            ST_RAMP: begin
                // Trip inputs are deliberately not looked at while ramping.
                if (!ps_act) begin
                    state_d = ST_IDLE;
                end else if (!permit) begin
                    state_d = ST_TRIP;
                    cause_d = CW'(CAUSE_PERMIT);
                end else if (cnt_q == RAMP_LAST) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SETTLE, ST_RUN: begin
                // Normal shutdown outranks faults; permit loss outranks trips.
                if (!ps_act) begin
                    state_d = ST_IDLE;
                end else if (!permit || (|trip_in)) begin
                    state_d   = ST_TRIP;
                    latched_d = trip_in;
                    cause_d   = permit ? trip_code : CW'(CAUSE_PERMIT);
                end else if (state_q == ST_SETTLE) begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_TRIP: begin
                // Acknowledge only counts once the operator has dropped ps_act.
                if (ack && !ps_act) begin
                    state_d   = ST_IDLE;
                    latched_d = '0;
                    cause_d   = CW'(CAUSE_NONE);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            trip_latched <= '0;
            first_cause  <= '0;
            on_perm      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            trip_latched <= latched_d;
            first_cause  <= cause_d;
            on_perm      <= permit;
        end
    end

    assign state      = state_q;
    assign ps_on      = (state_q == ST_RAMP) || (state_q == ST_SETTLE) || (state_q == ST_RUN);
    assign delay_done = (state_q == ST_SETTLE) || (state_q == ST_RUN);
    assign ca_ok      = (state_q == ST_RUN);

endmodule
